// File: rtl/uart_pkg.sv
// uart_pkg: shared types, baud constants and vote helper for the UART blocks
//   par_e      - parity selection (anything other than EVEN/ODD means none)
//   rx_state_e - receiver FSM states
//   BPS_DIV_*  - bps_div values for common baud rates at 50 MHz, OVERSAMPLE=16
//   maj3()     - 2-of-3 majority vote
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} par_e;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BRK} rx_state_e;
    localparam int unsigned BPS_DIV_9600   = 324;
    localparam int unsigned BPS_DIV_19200  = 162;
    localparam int unsigned BPS_DIV_38400  = 80;
    localparam int unsigned BPS_DIV_57600  = 53;
    localparam int unsigned BPS_DIV_115200 = 26;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: baud tick divider plus oversample index, both held at 0 while cleared
//   clk_i, rst_i - clock, synchronous active-high reset
//   clr_i        - hold counters at 0 (line idle)
//   div_i        - tick period minus one
//   tick_o       - one-cycle oversample tick
//   idx_o        - oversample index within the bit, 0..OVERSAMPLE-1, advances on tick_o
module uart_baud_tick #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic [DIV_W-1:0]              div_i,
    output logic                          tick_o,
    output logic [$clog2(OVERSAMPLE)-1:0] idx_o
);
    localparam int IDX_W = $clog2(OVERSAMPLE);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    assign tick_o = ~clr_i & (cnt_q == div_i);
    assign idx_o  = idx_q;
    always_comb begin
        cnt_d = (clr_i || tick_o) ? '0 : cnt_q + DIV_W'(1);
        idx_d = clr_i ? '0 : !tick_o ? idx_q : (idx_q == IDX_W'(OVERSAMPLE - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: configurable UART receiver (5..9 data bits, N/E/O parity, 1/2 stop) with valid/ready output
//   Clk, Rst      - clock, synchronous active-high reset
//   uart_rxd      - asynchronous serial input, idle high
//   bps_div       - oversample tick period minus one, latched at start bit
//   parity_mode   - 0 none, 1 even, 2 odd, 3 none; latched at start bit
//   stop2         - expect two stop bits; latched at start bit
//   Data_Byte     - received character (LSB first on the line)
//   Data_Valid    - character held; Data_Ready accepts it
//   Parity_Err    - parity mismatch on the held character
//   Frame_Err     - a stop bit read 0 on the held character
//   Break_Det     - one-cycle pulse when a break is recognised
//   Overrun       - sticky, a completed character was dropped; cleared by Ovr_Clr
//   Busy          - receiver is inside a frame or a break
module uart_rx_multi import uart_pkg::*; #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 uart_rxd,
    input  logic [DIV_W-1:0]     bps_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic [DATA_BITS-1:0] Data_Byte,
    output logic                 Data_Valid,
    input  logic                 Data_Ready,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Break_Det,
    output logic                 Overrun,
    input  logic                 Ovr_Clr,
    output logic                 Busy
);
    localparam int IDX_W  = $clog2(OVERSAMPLE);
    localparam int CNT_W  = 4;
    localparam int S_LO   = OVERSAMPLE / 2 - 1;
    localparam int S_MID  = OVERSAMPLE / 2;
    localparam int S_VOTE = OVERSAMPLE / 2 + 1;
    rx_state_e            state_q, state_d;
    logic                 meta_q, rxs_q, rxs_prev_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 pbit_q, pbit_d, pe_q, pe_d, fe_q, fe_d;
    logic                 cmpl_q, cmpl_d, brk_q, brk_d;
    logic [DATA_BITS-1:0] dat_q, dat_d;
    logic                 dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 tick, start_det, smp_lo, smp_mid, vote_en, bit_end, vote, par_en, load;
    logic [IDX_W-1:0]     idx;

    uart_baud_tick #(.OVERSAMPLE(OVERSAMPLE), .DIV_W(DIV_W)) u_tick (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .clr_i  (state_q == ST_IDLE),
        .div_i  (div_q),
        .tick_o (tick),
        .idx_o  (idx)
    );

    assign start_det  = (state_q == ST_IDLE) && rxs_prev_q && !rxs_q;
    assign smp_lo     = tick && (idx == IDX_W'(S_LO));
    assign smp_mid    = tick && (idx == IDX_W'(S_MID));
    assign vote_en    = tick && (idx == IDX_W'(S_VOTE));
    assign bit_end    = tick && (idx == IDX_W'(OVERSAMPLE - 1));
    assign vote       = maj3(samp_q[0], samp_q[1], rxs_q);
    assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    // A completed character is taken when the slot is free or being emptied this cycle.
    assign load       = cmpl_q && (!dv_q || Data_Ready);
    assign Data_Byte  = dat_q;
    assign Data_Valid = dv_q;
    assign Parity_Err = perr_q;
    assign Frame_Err  = ferr_q;
    assign Break_Det  = brk_q;
    assign Overrun    = ovr_q;
    assign Busy       = state_q != ST_IDLE;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pbit_d    = pbit_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        cmpl_d    = 1'b0;
        brk_d     = 1'b0;
        samp_d    = smp_lo ? {samp_q[1], rxs_q} : smp_mid ? {rxs_q, samp_q[0]} : samp_q;
        case (state_q)
            ST_IDLE: if (start_det) begin
                state_d   = ST_START;
                div_d     = bps_div;
                par_d     = parity_mode;
                stop2_d   = stop2;
                bit_cnt_d = '0;
                pbit_d    = 1'b0;
                pe_d      = 1'b0;
                fe_d      = 1'b0;
            end
            ST_START: state_d = (vote_en && vote) ? ST_IDLE : bit_end ? ST_DATA : state_q;
            ST_DATA: begin
                if (vote_en) begin
                    shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                if (bit_end && bit_cnt_q == CNT_W'(DATA_BITS))
                    state_d = par_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (vote_en) begin
                    pbit_d = vote;
                    pe_d   = vote != (^shift_q ^ (par_q == PAR_ODD));
                end
                if (bit_end)
                    state_d = ST_STOP1;
            end
            // Leave at the mid-bit vote so a back-to-back start edge is not missed.
            ST_STOP1: if (vote_en) begin
                if (!vote && shift_q == '0 && !pbit_q) begin
                    state_d = ST_BRK;
                    brk_d   = 1'b1;
                end else begin
                    fe_d    = !vote;
                    state_d = stop2_q ? ST_STOP2 : ST_IDLE;
                    cmpl_d  = !stop2_q;
                end
            end
            ST_STOP2: if (vote_en) begin
                fe_d    = fe_q | !vote;
                state_d = ST_IDLE;
                cmpl_d  = 1'b1;
            end
            ST_BRK: state_d = rxs_q ? ST_IDLE : state_q;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dat_d  = load ? shift_q : dat_q;
        perr_d = load ? pe_q : perr_q;
        ferr_d = load ? fe_q : ferr_q;
        dv_d   = load | (dv_q & !Data_Ready);
        ovr_d  = (cmpl_q & dv_q & !Data_Ready) | (ovr_q & !Ovr_Clr);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            div_q      <= '0;
            par_q      <= '0;
            stop2_q    <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            pbit_q     <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            cmpl_q     <= 1'b0;
            brk_q      <= 1'b0;
            dat_q      <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            meta_q     <= uart_rxd;
            rxs_q      <= meta_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            div_q      <= div_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pbit_q     <= pbit_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            cmpl_q     <= cmpl_d;
            brk_q      <= brk_d;
            dat_q      <= dat_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: directed and randomized frames against a queue-based character model
module tb_uart_rx_multi;
    import uart_pkg::*;
    typedef struct {int data; bit pe; bit fe;} exp_t;

    logic        clk = 0, rst = 1, rxd = 1, rxd7 = 1, rdy = 1, rdy7 = 0, ovr_clr = 0, stop2 = 0;
    logic [15:0] bps_div = 16'(BPS_DIV_115200);
    logic [1:0]  parity_mode = 2'd0;
    logic [7:0]  db;
    logic        dv, perr, ferr, brk, ovr, busy;
    logic [6:0]  db7;
    logic        dv7, perr7, ferr7, brk7, ovr7, busy7;
    int          checks = 0, errors = 0, bp = 16, rx_cnt = 0, exp_rx = 0, brk_cnt = 0, exp_brk = 0;
    bit          exp_ovr = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    uart_rx_multi #(.DATA_BITS(8)) u_dut (
        .Clk(clk), .Rst(rst), .uart_rxd(rxd), .bps_div(bps_div), .parity_mode(parity_mode),
        .stop2(stop2), .Data_Byte(db), .Data_Valid(dv), .Data_Ready(rdy), .Parity_Err(perr),
        .Frame_Err(ferr), .Break_Det(brk), .Overrun(ovr), .Ovr_Clr(ovr_clr), .Busy(busy)
    );

    uart_rx_multi #(.DATA_BITS(7)) u_dut7 (
        .Clk(clk), .Rst(rst), .uart_rxd(rxd7), .bps_div(bps_div), .parity_mode(parity_mode),
        .stop2(stop2), .Data_Byte(db7), .Data_Valid(dv7), .Data_Ready(rdy7), .Parity_Err(perr7),
        .Frame_Err(ferr7), .Break_Det(brk7), .Overrun(ovr7), .Ovr_Clr(ovr_clr), .Busy(busy7)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int d);
        bps_div = 16'(d);
        bp = (d + 1) * 16;
    endtask

    task automatic drive(input bit v, input bit use7);
        if (use7) rxd7 = v;
        else rxd = v;
        step(bp);
    endtask

    // Model: expected character, flags, break and overrun follow from the bits put on the line.
    task automatic send_frame(input int d, input int nb, input int pm, input bit s2, input bit pflip,
                              input bit st1, input bit st2v, input bit use7, input int gap, output exp_t eo);
        logic [15:0] div_save;
        int dm;
        bit pen, pbit, is_brk;
        div_save = bps_div;
        dm       = d & ((1 << nb) - 1);
        pen      = (pm == 1) || (pm == 2);
        pbit     = pen && ((^dm) ^ (pm == 2) ^ pflip);
        is_brk   = (dm == 0) && !pbit && !st1;
        eo.data  = dm;
        eo.pe    = pen && pflip;
        eo.fe    = !st1 || (s2 && !st2v);
        parity_mode = 2'(pm);
        stop2       = s2;
        drive(1'b0, use7);
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
        bps_div     = 16'($urandom_range(0, 40));
        for (int i = 0; i < nb; i++) drive(dm[i], use7);
        if (pen) drive(pbit, use7);
        if (!use7) begin
            if (is_brk) exp_brk++;
            else if (!rdy && exp_q.size() > 0) exp_ovr = 1;
            else begin
                exp_q.push_back(eo);
                exp_rx++;
            end
        end
        drive(st1, use7);
        if (s2) drive(st2v, use7);
        parity_mode = 2'(pm);
        stop2       = s2;
        bps_div     = div_save;
        repeat (gap) drive(1'b1, use7);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 40 * bp) begin
            step(1);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic wait_dv7();
        int n = 0;
        while (!dv7 && n < 20 * bp) begin
            step(1);
            n++;
        end
        check_eq("dv7_arrive", dv7, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (brk) brk_cnt++;
            if (dv && rdy) begin
                rx_cnt++;
                check_eq("dv_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("rx_byte", db, mon_e.data);
                    check_eq("rx_perr", perr, mon_e.pe);
                    check_eq("rx_ferr", ferr, mon_e.fe);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int n;
        set_div(BPS_DIV_115200);
        step(4);
        check_eq("rst_outs", {db, dv, perr, ferr, brk, ovr, busy}, 0);
        check_eq("rst_outs7", {db7, dv7, perr7, ferr7, brk7, ovr7, busy7}, 0);
        rst = 0;
        step(2);
        // 8N1 back-to-back at 115200
        send_frame(8'hA5, 8, 0, 0, 0, 1, 1, 0, 0, e);
        send_frame(8'h3C, 8, 0, 0, 0, 1, 1, 0, 2, e);
        wait_drain();
        check_eq("b2b_count", rx_cnt, 2);
        // 8E1 wrong then right parity
        set_div(3);
        send_frame(8'h07, 8, 1, 0, 1, 1, 1, 0, 2, e);
        wait_drain();
        send_frame(8'h03, 8, 1, 0, 0, 1, 1, 0, 2, e);
        wait_drain();
        check_eq("par_count", rx_cnt, exp_rx);
        // short low glitch on idle line
        rxd = 0;
        step(5);
        check_eq("glitch_busy", busy, 1);
        rxd = 1;
        n = 0;
        while (busy && n < bp) begin
            step(1);
            n++;
        end
        check_eq("glitch_idle", busy, 0);
        check_eq("glitch_no_rx", rx_cnt, exp_rx);
        check_eq("glitch_flags", {perr, ferr, ovr}, 0);
        // break: line low for two frame times
        parity_mode = 0;
        stop2 = 0;
        rxd = 0;
        step(20 * bp);
        rxd = 1;
        step(2 * bp);
        exp_brk++;
        check_eq("brk_pulses", brk_cnt, exp_brk);
        check_eq("brk_no_rx", rx_cnt, exp_rx);
        check_eq("brk_idle", busy, 0);
        send_frame(8'h55, 8, 0, 0, 0, 1, 1, 0, 2, e);
        wait_drain();
        check_eq("after_brk_count", rx_cnt, exp_rx);
        // overrun with consumer stalled
        rdy = 0;
        send_frame(8'h11, 8, 0, 0, 0, 1, 1, 0, 2, e);
        send_frame(8'h22, 8, 0, 0, 0, 1, 1, 0, 2, e);
        check_eq("ovr_dv", dv, 1);
        check_eq("ovr_held", db, 8'h11);
        check_eq("ovr_set", ovr, exp_ovr);
        ovr_clr = 1;
        step(1);
        ovr_clr = 0;
        exp_ovr = 0;
        step(1);
        check_eq("ovr_clr", ovr, exp_ovr);
        rdy = 1;
        wait_drain();
        check_eq("ovr_count", rx_cnt, exp_rx);
        // 7O2 with bad second stop, then reset mid-frame, then clean frame
        send_frame(8'h41, 7, 2, 1, 0, 1, 0, 1, 2, e);
        wait_dv7();
        check_eq("f7_byte", db7, e.data);
        check_eq("f7_ferr", ferr7, e.fe);
        check_eq("f7_perr", perr7, e.pe);
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 1);
        rst = 1;
        rxd7 = 1;
        step(2);
        check_eq("mid_rst_outs7", {db7, dv7, perr7, ferr7, brk7, ovr7, busy7}, 0);
        rst = 0;
        step(2);
        check_eq("post_rst_outs7", {db7, dv7, perr7, ferr7, brk7, ovr7, busy7}, 0);
        send_frame(8'h2A, 7, 2, 1, 0, 1, 1, 1, 2, e);
        wait_dv7();
        check_eq("clean7_byte", db7, 8'h2A);
        check_eq("clean7_flags", {perr7, ferr7, ovr7}, {e.pe, e.fe, 1'b0});
        // randomized frames on the 8-bit receiver
        for (int k = 0; k < 24; k++) begin
            set_div($urandom_range(1, 4));
            send_frame(($urandom_range(0, 3) == 0) ? 0 : int'($urandom), 8, $urandom_range(0, 3),
                       1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       0, 2, e);
            wait_drain();
        end
        check_eq("rand_rx_count", rx_cnt, exp_rx);
        check_eq("rand_brk_count", brk_cnt, exp_brk);
        check_eq("rand_ovr", ovr, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
